// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: state enum, width codes,
// byte-mask, alignment and load-extension functions.
package lsu_pkg;

    localparam int unsigned REG_W = 64;
    localparam int unsigned WDT_W = 3;

    localparam logic [REG_W-1:0] RAM_ADDR = REG_W'(64'h0000_0000_8000_0000);

    localparam logic [WDT_W-1:0] WDT8  = WDT_W'(0);
    localparam logic [WDT_W-1:0] WDT16 = WDT_W'(1);
    localparam logic [WDT_W-1:0] WDT32 = WDT_W'(2);
    localparam logic [WDT_W-1:0] WDT64 = WDT_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    function automatic logic [7:0] wdt_mask(input logic [WDT_W-1:0] wdt);
        case (wdt)
            WDT8:    return 8'h01;
            WDT16:   return 8'h03;
            WDT32:   return 8'h0F;
            WDT64:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Unknown width codes count as misaligned so they are answered with an error.
    function automatic logic is_aligned(input logic [WDT_W-1:0] wdt, input logic [2:0] off);
        case (wdt)
            WDT8:    return 1'b1;
            WDT16:   return off[0] == 1'b0;
            WDT32:   return off[1:0] == 2'b00;
            WDT64:   return off == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] extend_load(input logic [REG_W-1:0] d,
                                                     input logic [WDT_W-1:0] wdt,
                                                     input logic sext);
        case (wdt)
            WDT8:    return sext ? {{(REG_W-8){d[7]}}, d[7:0]}    : {{(REG_W-8){1'b0}}, d[7:0]};
            WDT16:   return sext ? {{(REG_W-16){d[15]}}, d[15:0]} : {{(REG_W-16){1'b0}}, d[15:0]};
            WDT32:   return sext ? {{(REG_W-32){d[31]}}, d[31:0]} : {{(REG_W-32){1'b0}}, d[31:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: shifts store data and mask up to the lane offset and
// extracts/extends load data from the aligned read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [WDT_W-1:0] wdt,
    input  logic [2:0]       off,
    input  logic             sext,
    input  logic [REG_W-1:0] wdata,
    input  logic [REG_W-1:0] rdata,
    output logic [REG_W-1:0] wdata_c,
    output logic [7:0]       wmask_c,
    output logic [REG_W-1:0] rdata_c
);

    logic [5:0] bit_sh;

    assign bit_sh  = {off, 3'b000};
    assign wdata_c = wdata << bit_sh;
    assign wmask_c = wdt_mask(wdt) << off;
    assign rdata_c = extend_load(rdata >> bit_sh, wdt, sext);

endmodule

// File: rtl/lsu_req.sv
// Load/store initiator: one outstanding EXU request, alignment/window checks,
// 8-byte-aligned memory transaction and extended load response.
module lsu_req
    import lsu_pkg::*;
#(
    parameter logic [REG_W-1:0] RAM_BASE  = RAM_ADDR,
    parameter logic [REG_W-1:0] RAM_BYTES = REG_W'(1024)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [REG_W-1:0] req_addr,
    input  logic [REG_W-1:0] req_wdata,
    input  logic [WDT_W-1:0] req_wdt,
    input  logic             req_sext,
    output logic             rsp_valid,
    output logic [REG_W-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [REG_W-1:0] mem_addr,
    output logic [REG_W-1:0] mem_wdata,
    output logic [7:0]       mem_wmask,
    input  logic             mem_ready,
    input  logic             mem_rvalid,
    input  logic [REG_W-1:0] mem_rdata
);

    lsu_state_e       state;
    logic             wen_q;
    logic [2:0]       off_q;
    logic [REG_W-1:0] wdata_q;
    logic [WDT_W-1:0] wdt_q;
    logic             sext_q;
    logic             err_q;

    logic             in_idle;
    logic [REG_W-1:0] win_off;
    logic             req_err;
    logic [WDT_W-1:0] lane_wdt;
    logic [2:0]       lane_off;
    logic             lane_sext;
    logic [REG_W-1:0] lane_wdata;
    logic [REG_W-1:0] lane_wdata_c;
    logic [7:0]       lane_wmask_c;
    logic [REG_W-1:0] lane_rdata_c;

    assign in_idle   = (state == ST_IDLE);
    assign req_ready = in_idle;

    // Unsigned wrap makes addresses below the base fail the window check too.
    assign win_off = req_addr - RAM_BASE;
    assign req_err = !is_aligned(req_wdt, req_addr[2:0]) || (win_off >= RAM_BYTES);

    // Lane logic sees the live request while idle (strobes are registered on accept).
    assign lane_wdt   = in_idle ? req_wdt       : wdt_q;
    assign lane_off   = in_idle ? req_addr[2:0] : off_q;
    assign lane_sext  = in_idle ? req_sext      : sext_q;
    assign lane_wdata = in_idle ? req_wdata     : wdata_q;

    lsu_lane u_lane (
        .wdt     (lane_wdt),
        .off     (lane_off),
        .sext    (lane_sext),
        .wdata   (lane_wdata),
        .rdata   (mem_rdata),
        .wdata_c (lane_wdata_c),
        .wmask_c (lane_wmask_c),
        .rdata_c (lane_rdata_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wen_q     <= 1'b0;
            off_q     <= '0;
            wdata_q   <= '0;
            wdt_q     <= '0;
            sext_q    <= 1'b0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q     <= req_wen;
                        off_q     <= req_addr[2:0];
                        wdata_q   <= req_wdata;
                        wdt_q     <= req_wdt;
                        sext_q    <= req_sext;
                        err_q     <= req_err;
                        rsp_rdata <= '0;
                        if (req_err) begin
                            state <= ST_RESP;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_ren   <= !req_wen;
                            mem_wen   <= req_wen;
                            mem_addr  <= {req_addr[REG_W-1:3], 3'b000};
                            mem_wdata <= lane_wdata_c;
                            mem_wmask <= lane_wmask_c;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        mem_ren <= 1'b0;
                        mem_wen <= 1'b0;
                        state   <= wen_q ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        rsp_rdata <= lane_rdata_c;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_req.sv
// Self-checking bench for lsu_req: directed cases, then random loads/stores against
// a byte-array reference model and a simple ram responder.
module tb_lsu_req;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_sext;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_wdt;
    logic        rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        mem_ren, mem_wen;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ram     [BYTES];
    logic [7:0] ref_mem [BYTES];

    int stall_left = 0;
    bit ready_rand = 1'b0;
    int rv_delay   = 0;
    int ren_cnt    = 0;
    int wen_cnt    = 0;
    int stray      = 0;
    bit pend_act   = 1'b0;
    int pend_cnt   = 0;
    logic [63:0] pend_data = '0;

    always #5 clk = ~clk;

    lsu_req #(.RAM_BASE(BASE), .RAM_BYTES(64'(BYTES))) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wdt    (req_wdt),
        .req_sext   (req_sext),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Ready generator: forced stalls first, otherwise random or always-ready.
    always @(posedge clk) begin
        #2;
        if (stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Ram responder: byte-masked writes, registered read with optional extra delay.
    always @(posedge clk) begin : ram_model
        logic [63:0] word;
        int idx;
        mem_rvalid <= 1'b0;
        if (mem_ren) ren_cnt++;
        if (mem_wen) wen_cnt++;
        if (pend_act) begin
            if (pend_cnt == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend_data;
                pend_act = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if ((mem_ren || mem_wen) && mem_ready) begin
            if (mem_addr - BASE >= 64'(BYTES)) begin
                stray++;
            end else begin
                idx = int'(mem_addr - BASE);
                if (mem_wen) begin
                    for (int k = 0; k < 8; k++)
                        if (mem_wmask[k]) ram[idx+k] = mem_wdata[8*k +: 8];
                end else begin
                    word = '0;
                    for (int k = 0; k < 8; k++) word[8*k +: 8] = ram[idx+k];
                    if (rv_delay == 0) begin
                        mem_rvalid <= 1'b1;
                        mem_rdata  <= word;
                    end else begin
                        pend_act  = 1'b1;
                        pend_cnt  = rv_delay - 1;
                        pend_data = word;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [2:0] wdt, input bit sext);
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wdt   = wdt;
        req_sext  = sext;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycles from accepting edge until rsp_valid is seen; -1 on timeout.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
    endtask

    // Reference behaviour: byte-addressed little-endian memory with natural alignment.
    task automatic model(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [2:0] wdt, input bit sext,
                         output bit err, output logic [63:0] rd);
        int size;
        int off;
        logic [63:0] val;
        size = (wdt == 3'd0) ? 1 : (wdt == 3'd1) ? 2 : (wdt == 3'd2) ? 4 : (wdt == 3'd3) ? 8 : 0;
        err  = (size == 0) || (addr < BASE) || (addr >= BASE + 64'(BYTES)) ||
               ((addr % 64'(size)) != 0);
        rd   = '0;
        if (!err) begin
            off = int'(addr - BASE);
            if (wen) begin
                for (int k = 0; k < size; k++) ref_mem[off+k] = 8'(wdata >> (8*k));
            end else begin
                val = '0;
                for (int k = 0; k < size; k++) val = val | (64'(ref_mem[off+k]) << (8*k));
                if (sext && size < 8 && val[8*size-1])
                    val = val | ~((64'd1 << (8*size)) - 64'd1);
                rd = val;
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int r0;
        int seen;
        int diffs;
        bit exp_err;
        logic [63:0] exp_rd;
        bit wen;
        bit sext;
        logic [2:0] wdt;
        logic [63:0] addr;
        logic [63:0] wdata;
        int sz;
        int off;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wdt   = '0;
        req_sext  = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            ram[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_rsp_rdata", rsp_rdata,      64'd0);
        chk("rst_mem_ren",   64'(mem_ren),   64'd0);
        chk("rst_mem_wen",   64'(mem_wen),   64'd0);
        chk("rst_mem_addr",  mem_addr,       64'd0);
        chk("rst_mem_wdata", mem_wdata,      64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // sd then ld at BASE+8
        send(1'b1, BASE + 64'd8, 64'h1122334455667788, 3'd3, 1'b0);
        chk("sd_wen",   64'(mem_wen),   64'd1);
        chk("sd_ren",   64'(mem_ren),   64'd0);
        chk("sd_mask",  64'(mem_wmask), 64'hFF);
        chk("sd_addr",  mem_addr,       BASE + 64'd8);
        chk("sd_wdata", mem_wdata,      64'h1122334455667788);
        wait_rsp(lat);
        chk("sd_lat",   64'(lat),       64'd3);
        chk("sd_err",   64'(rsp_err),   64'd0);
        chk("sd_rdata", rsp_rdata,      64'd0);

        send(1'b0, BASE + 64'd8, 64'd0, 3'd3, 1'b1);
        chk("ld_ren",   64'(mem_ren),   64'd1);
        wait_rsp(lat);
        chk("ld_lat",   64'(lat),       64'd4);
        chk("ld_rdata", rsp_rdata,      64'h1122334455667788);

        // sb 0xAB at +5, then lb signed and unsigned
        send(1'b1, BASE + 64'd5, 64'hAB, 3'd0, 1'b0);
        chk("sb_mask", 64'(mem_wmask),        64'h20);
        chk("sb_lane", 64'(mem_wdata[47:40]), 64'hAB);
        chk("sb_addr", mem_addr,              BASE);
        wait_rsp(lat);
        chk("sb_lat",  64'(lat),              64'd3);

        send(1'b0, BASE + 64'd5, 64'd0, 3'd0, 1'b1);
        wait_rsp(lat);
        chk("lb_sext", rsp_rdata, 64'hFFFFFFFFFFFFFFAB);
        send(1'b0, BASE + 64'd5, 64'd0, 3'd0, 1'b0);
        wait_rsp(lat);
        chk("lb_zext", rsp_rdata, 64'h00000000000000AB);

        // lw at +4 with upper half 0x80000001
        ram[4] = 8'h01;
        ram[5] = 8'h00;
        ram[6] = 8'h00;
        ram[7] = 8'h80;
        send(1'b0, BASE + 64'd4, 64'd0, 3'd2, 1'b1);
        wait_rsp(lat);
        chk("lw_sext", rsp_rdata, 64'hFFFFFFFF80000001);

        // Error cases: misaligned lh, ld below window, unknown width
        r0 = ren_cnt + wen_cnt;
        send(1'b0, BASE + 64'd3, 64'd0, 3'd1, 1'b1);
        chk("lh_mis_ren", 64'(mem_ren), 64'd0);
        wait_rsp(lat);
        chk("lh_mis_lat",   64'(lat),     64'd2);
        chk("lh_mis_err",   64'(rsp_err), 64'd1);
        chk("lh_mis_rdata", rsp_rdata,    64'd0);

        send(1'b0, BASE - 64'd8, 64'd0, 3'd3, 1'b0);
        wait_rsp(lat);
        chk("ld_low_lat",   64'(lat),     64'd2);
        chk("ld_low_err",   64'(rsp_err), 64'd1);
        chk("ld_low_rdata", rsp_rdata,    64'd0);

        send(1'b0, BASE, 64'd0, 3'd5, 1'b0);
        wait_rsp(lat);
        chk("bad_wdt_err", 64'(rsp_err), 64'd1);
        chk("err_no_strobe", 64'(ren_cnt + wen_cnt - r0), 64'd0);

        // Backpressure: six cycles without mem_ready, strobes must hold
        stall_left = 6;
        send(1'b1, BASE + 64'd18, 64'h1234, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_wen",   64'(mem_wen),   64'd1);
            chk("bp_addr",  mem_addr,       BASE + 64'd16);
            chk("bp_mask",  64'(mem_wmask), 64'h0C);
            chk("bp_wdata", mem_wdata,      64'h0000_0000_1234_0000);
            @(negedge clk);
        end
        wait_rsp(lat);
        chk("bp_lat", 64'(lat), 64'd4);
        chk("bp_ram", {48'd0, ram[19], ram[18]}, 64'h1234);

        // Reset while waiting for read data; the late rvalid must be ignored
        rv_delay = 3;
        send(1'b0, BASE + 64'd8, 64'd0, 3'd3, 1'b0);
        chk("rw_ren_issue", 64'(mem_ren), 64'd1);
        @(negedge clk);
        chk("rw_ren_wait", 64'(mem_ren), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_req_ready", 64'(req_ready), 64'd1);
        chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rw_rsp_rdata", rsp_rdata,      64'd0);
        chk("rw_mem_ren",   64'(mem_ren),   64'd0);
        chk("rw_mem_addr",  mem_addr,       64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1;
        end
        chk("rw_late_rvalid", 64'(seen), 64'd0);
        rv_delay = 0;

        // Random phase against the reference model
        for (int i = 0; i < BYTES; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ready_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            wen   = 1'($urandom_range(0, 1));
            sext  = 1'($urandom_range(0, 1));
            wdt   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            wdata = {$urandom, $urandom};
            sz    = (wdt < 3'd4) ? (1 << wdt) : 1;
            off   = $urandom_range(0, BYTES - 1);
            if ($urandom_range(0, 3) != 0) off = off - (off % sz);
            case ($urandom_range(0, 19))
                0:       addr = BASE - 64'(8 * $urandom_range(1, 4));
                1:       addr = BASE + 64'(BYTES) + 64'($urandom_range(0, 15));
                default: addr = BASE + 64'(off);
            endcase
            rv_delay = $urandom_range(0, 2);
            model(wen, addr, wdata, wdt, sext, exp_err, exp_rd);
            r0 = ren_cnt + wen_cnt;
            send(wen, addr, wdata, wdt, sext);
            wait_rsp(lat);
            chk("rnd_rsp_seen", 64'(lat > 0), 64'd1);
            if (lat <= 0) break;
            chk("rnd_err",   64'(rsp_err), 64'(exp_err));
            chk("rnd_rdata", rsp_rdata,    exp_rd);
            if (exp_err) chk("rnd_err_no_strobe", 64'(ren_cnt + wen_cnt - r0), 64'd0);
        end

        diffs = 0;
        for (int i = 0; i < BYTES; i++)
            if (ram[i] !== ref_mem[i]) diffs++;
        chk("ram_image", 64'(diffs), 64'd0);
        chk("stray_strobes", 64'(stray), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
